pll_speed_sequencer: RTL and testbench



---
 rtl/pll_speed_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_pll_speed_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_speed_sequencer.sv
// Sequences Avalon-MM reconfiguration writes to the system PLL when the CPU speed,
// UART speed or CPU reset changes, then supervises lock with done/error reporting.
module pll_speed_sequencer #(
  parameter int LOCK_SETTLE  = 16,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  speed_in,
  input  logic [1:0]  uspeed_in,
  input  logic        cpu_reset_in,
  input  logic        pll_locked,
  input  logic        cfg_waitrequest,
  output logic        cfg_write,
  output logic [5:0]  cfg_address,
  output logic [31:0] cfg_data,
  output logic        busy,
  output logic        done,
  output logic        lock_err
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_MODE  = 4'd1;
  localparam logic [3:0] S_G1      = 4'd2;
  localparam logic [3:0] S_W_CS    = 4'd3;
  localparam logic [3:0] S_G2      = 4'd4;
  localparam logic [3:0] S_W_CU    = 4'd5;
  localparam logic [3:0] S_G3      = 4'd6;
  localparam logic [3:0] S_W_START = 4'd7;
  localparam logic [3:0] S_SETTLE  = 4'd8;
  localparam logic [3:0] S_LOCK    = 4'd9;

  localparam int SW = (LOCK_SETTLE  > 1) ? $clog2(LOCK_SETTLE)  : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);

  logic [2:0]    r_spd_s1, r_spd_s2, r_spd_f, r_spd_app;
  logic [1:0]    r_usp_s1, r_usp_s2, r_usp_f, r_usp_app;
  logic          r_crst_s1, r_crst_s2, r_crst_f, r_crst_d;
  logic          r_rst_pend;
  logic [3:0]    r_state;
  logic [SW-1:0] r_settle_cnt;
  logic [TW-1:0] r_tmo_cnt;

  logic          w_rst_fall;
  logic          w_trigger;
  logic [31:0]   w_spd_data;
  logic [31:0]   w_usp_data;

  // Two-flop synchronizers; the filtered copy only follows once both stages agree,
  // so an input that changes every cycle never reaches the comparison.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spd_s1  <= '0;
      r_spd_s2  <= '0;
      r_spd_f   <= '0;
      r_usp_s1  <= '0;
      r_usp_s2  <= '0;
      r_usp_f   <= '0;
      r_crst_s1 <= 1'b0;
      r_crst_s2 <= 1'b0;
      r_crst_f  <= 1'b0;
      r_crst_d  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
      r_spd_s1  <= speed_in;
      r_spd_s2  <= r_spd_s1;
      r_usp_s1  <= uspeed_in;
      r_usp_s2  <= r_usp_s1;
      r_crst_s1 <= cpu_reset_in;
      r_crst_s2 <= r_crst_s1;
      r_crst_d  <= r_crst_f;
      if (r_spd_s1 == r_spd_s2)   r_spd_f  <= r_spd_s2;
      if (r_usp_s1 == r_usp_s2)   r_usp_f  <= r_usp_s2;
      if (r_crst_s1 == r_crst_s2) r_crst_f <= r_crst_s2;
    end
  end

  assign w_rst_fall = r_crst_d & ~r_crst_f;
  assign w_trigger  = (r_spd_f != r_spd_app) || (r_usp_f != r_usp_app) || r_rst_pend;

  always_comb begin
    // NOTE: a default before the case keeps this purely combinational (no latch).
    w_spd_data = 32'h0000_0505;
    case (r_spd_app)
      3'd1:    w_spd_data = 32'h0002_0504;
      3'd2:    w_spd_data = 32'h0000_1E1E;
      3'd3:    w_spd_data = 32'h0000_0F0F;
      3'd4:    w_spd_data = 32'h0000_0808;
      default: w_spd_data = 32'h0000_0505;
    endcase
  end

  always_comb begin
    w_usp_data = 32'h0004_9696;
    case (r_usp_app)
      2'd0:    w_usp_data = 32'h0004_0909;
      2'd1:    w_usp_data = 32'h0004_F4F4;
      default: w_usp_data = 32'h0004_9696;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_spd_app    <= '0;
      r_usp_app    <= '0;
      r_rst_pend   <= 1'b0;
      r_settle_cnt <= '0;
      r_tmo_cnt    <= '0;
      cfg_write    <= 1'b0;
      cfg_address  <= '0;
      cfg_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      lock_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_rst_fall) r_rst_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_trigger && pll_locked) begin
            r_spd_app   <= r_spd_f;
            r_usp_app   <= r_usp_f;
            // A reset fall landing on this very edge still earns its own sequence.
            r_rst_pend  <= w_rst_fall;
            lock_err    <= 1'b0;
            busy        <= 1'b1;
            r_state     <= S_W_MODE;
            cfg_write   <= 1'b1;
            cfg_address <= 6'd0;
            cfg_data    <= 32'd0;
          end
        end
        S_W_MODE: begin
          if (!cfg_waitrequest) begin
            cfg_write <= 1'b0;
            r_state   <= S_G1;
          end
        end
        S_G1: begin
          r_state     <= S_W_CS;
          cfg_write   <= 1'b1;
          cfg_address <= 6'd5;
          cfg_data    <= w_spd_data;
        end
        S_W_CS: begin
          if (!cfg_waitrequest) begin
            cfg_write <= 1'b0;
            r_state   <= S_G2;
          end
        end
        S_G2: begin
          r_state     <= S_W_CU;
          cfg_write   <= 1'b1;
          cfg_address <= 6'd5;
          cfg_data    <= w_usp_data;
        end
        S_W_CU: begin
          if (!cfg_waitrequest) begin
            cfg_write <= 1'b0;
            r_state   <= S_G3;
          end
        end
        S_G3: begin
          r_state     <= S_W_START;
          cfg_write   <= 1'b1;
          cfg_address <= 6'd2;
          cfg_data    <= 32'd0;
        end
        S_W_START: begin
          if (!cfg_waitrequest) begin
            cfg_write    <= 1'b0;
            r_settle_cnt <= '0;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_tmo_cnt <= '0;
            r_state   <= S_LOCK;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_LOCK: begin
          if (pll_locked) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_tmo_cnt == TMO_LAST) begin
            lock_err <= 1'b1;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: begin
          cfg_write <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_speed_sequencer.sv
// Scoreboard bench for pll_speed_sequencer: stimulus pushes expected writes and
// sequence endings, a negedge monitor pops and compares them as the DUT produces them.
module tb_pll_speed_sequencer;

  localparam int SETTLE = 8;
  localparam int TMO    = 64;
  localparam int K_WR   = 0;
  localparam int K_END  = 1;

  typedef struct {
    int          kind;
    logic [5:0]  addr;
    logic [31:0] data;
    int          hold;
    int          gap;
    logic        dn;
    logic        er;
    int          len;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  speed_in = '0;
  logic [1:0]  uspeed_in = '0;
  logic        cpu_reset_in = 1'b0;
  logic        pll_locked = 1'b1;
  logic        cfg_waitrequest = 1'b0;
  logic        cfg_write;
  logic [5:0]  cfg_address;
  logic [31:0] cfg_data;
  logic        busy, done, lock_err;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err = 0;
  int   stall_n = 0;
  int   ws_cnt = 0;
  int   hold_cnt = 0;
  int   gap_cnt = 0;
  int   busy_len = 0;
  logic prev_busy = 1'b0;
  logic mon_en = 1'b1;

  pll_speed_sequencer #(.LOCK_SETTLE(SETTLE), .LOCK_TIMEOUT(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .speed_in        (speed_in),
    .uspeed_in       (uspeed_in),
    .cpu_reset_in    (cpu_reset_in),
    .pll_locked      (pll_locked),
    .cfg_waitrequest (cfg_waitrequest),
    .cfg_write       (cfg_write),
    .cfg_address     (cfg_address),
    .cfg_data        (cfg_data),
    .busy            (busy),
    .done            (done),
    .lock_err        (lock_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [31:0] d, input int h, input int g);
    exp_t e;
    e.kind = K_WR; e.addr = a; e.data = d; e.hold = h; e.gap = g;
    e.dn = 1'b0; e.er = 1'b0; e.len = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [31:0] d_spd, input logic [31:0] d_usp, input int h,
                          input logic dn, input logic er, input int len);
    exp_t e;
    push_wr(6'd0, 32'd0, h, 0);
    push_wr(6'd5, d_spd, h, 1);
    push_wr(6'd5, d_usp, h, 1);
    push_wr(6'd2, 32'd0, h, 1);
    e.kind = K_END; e.addr = '0; e.data = '0; e.hold = 0; e.gap = 0;
    e.dn = dn; e.er = er; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd1);
  endtask

  task automatic count_busy(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy || cfg_write) cnt++;
    end
  endtask

  // Waitrequest responder, then monitor; both sample half a cycle away from the active edge.
  always @(negedge clk) begin
    if (cfg_write) begin
      if (ws_cnt < stall_n) begin
        cfg_waitrequest = 1'b1;
        ws_cnt++;
      end else begin
        cfg_waitrequest = 1'b0;
      end
    end else begin
      cfg_waitrequest = 1'b0;
      ws_cnt = 0;
    end

    if (mon_en && !reset) begin
      if (busy && !prev_busy) begin
        gap_cnt  = 0;
        busy_len = 0;
        check("err_clear_on_start", 32'(lock_err), 32'd0);
      end
      if (busy) busy_len++;
      if (cfg_write) begin
        hold_cnt++;
        if (!cfg_waitrequest) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_write: actual addr=%0d data=0x%0h required none", cfg_address, cfg_data);
          end else begin
            mon_e = exp_q.pop_front();
            check("kind_write", 32'(K_WR), 32'(mon_e.kind));
            check("wr_addr", 32'(cfg_address), 32'(mon_e.addr));
            check("wr_data", cfg_data, mon_e.data);
            check("wr_hold", 32'(hold_cnt), 32'(mon_e.hold));
            check("wr_gap", 32'(gap_cnt), 32'(mon_e.gap));
          end
          hold_cnt = 0;
          gap_cnt  = 0;
        end
      end else if (busy) begin
        gap_cnt++;
      end
      if (done) check("done_at_busy_fall", 32'(prev_busy && !busy), 32'd1);
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_end: actual done=%0b lock_err=%0b required none", done, lock_err);
        end else begin
          mon_e = exp_q.pop_front();
          check("kind_end", 32'(K_END), 32'(mon_e.kind));
          check("end_done", 32'(done), 32'(mon_e.dn));
          check("end_lock_err", 32'(lock_err), 32'(mon_e.er));
          if (mon_e.len >= 0) check("busy_len", 32'(busy_len), 32'(mon_e.len));
        end
      end
    end
    prev_busy = busy;
  end

  initial begin
    int n;
    int bad;

    // Reset state and quiet idle
    repeat (3) @(negedge clk);
    check("rst_outputs", {cfg_write, busy, done, lock_err, cfg_address, cfg_data}, 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (cfg_write || busy || done || lock_err || (|cfg_address) || (|cfg_data)) bad++;
    end
    check("idle_outputs_zero", 32'(bad), 32'd0);

    // speed 0 -> 3, no stalls, trigger latency
    push_seq(32'h0000_0F0F, 32'h0004_0909, 1, 1'b1, 1'b0, 7 + SETTLE + 1);
    @(negedge clk);
    speed_in = 3'd3;
    n = 0;
    while (!busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("trig_latency", 32'(n), 32'd4);
    wait_drained("drain_speed3");

    // uspeed 1 with three stall cycles on every write
    stall_n = 3;
    push_seq(32'h0000_0F0F, 32'h0004_F4F4, 4, 1'b1, 1'b0, 7 + SETTLE + 1 + 12);
    uspeed_in = 2'd1;
    wait_drained("drain_stall");
    stall_n = 0;

    // speed toggling every cycle must never trigger
    repeat (5) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      speed_in = (i % 2 == 0) ? 3'd1 : 3'd2;
      if (busy || cfg_write) bad++;
    end
    check("toggle_no_trigger", 32'(bad), 32'd0);
    push_seq(32'h0000_0505, 32'h0004_F4F4, 1, 1'b1, 1'b0, 7 + SETTLE + 1);
    speed_in = 3'd6;
    wait_drained("drain_speed6");

    // CPU reset pulse, then speed change mid-sequence: exactly two sequences
    push_seq(32'h0000_0505, 32'h0004_F4F4, 1, 1'b1, 1'b0, 7 + SETTLE + 1);
    push_seq(32'h0000_0808, 32'h0004_F4F4, 1, 1'b1, 1'b0, 7 + SETTLE + 1);
    cpu_reset_in = 1'b1;
    repeat (6) @(negedge clk);
    cpu_reset_in = 1'b0;
    wait_busy("busy_after_cpu_reset");
    repeat (3) @(negedge clk);
    speed_in = 3'd4;
    wait_drained("drain_two_seq");
    count_busy(40, bad);
    check("no_third_seq", 32'(bad), 32'd0);

    // lock timeout, pending trigger while unlocked, error cleared by next sequence
    push_seq(32'h0000_1E1E, 32'h0004_F4F4, 1, 1'b0, 1'b1, -1);
    speed_in = 3'd2;
    wait_busy("busy_before_timeout");
    pll_locked = 1'b0;
    wait_drained("drain_timeout");
    check("lock_err_set", 32'(lock_err), 32'd1);
    check("busy_low_after_timeout", 32'(busy), 32'd0);
    uspeed_in = 2'd2;
    count_busy(20, bad);
    check("no_start_unlocked", 32'(bad), 32'd0);
    check("lock_err_sticky", 32'(lock_err), 32'd1);
    push_seq(32'h0000_1E1E, 32'h0004_9696, 1, 1'b1, 1'b0, 7 + SETTLE + 1);
    pll_locked = 1'b1;
    wait_drained("drain_after_timeout");
    check("lock_err_cleared", 32'(lock_err), 32'd0);

    // asynchronous reset during a stalled write; the write is not replayed
    mon_en  = 1'b0;
    stall_n = 1000;
    speed_in = 3'd7;
    n = 0;
    while (!cfg_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("write_before_reset", 32'(cfg_write), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_write_drop", 32'(cfg_write), 32'd0);
    check("async_busy_drop", 32'(busy), 32'd0);
    speed_in  = 3'd0;
    uspeed_in = 2'd0;
    repeat (3) @(negedge clk);
    stall_n = 0;
    reset = 1'b0;
    count_busy(50, bad);
    check("no_replay_after_reset", 32'(bad), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
